// File: rtl/io_map_pkg.sv
// Register map and shared types for the board input reader.
// Offsets are relative to a 16-byte aligned window.
package io_map_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_0000;

  localparam logic [3:0] REG_SW   = 4'h0;
  localparam logic [3:0] REG_BTN  = 4'h4;
  localparam logic [3:0] REG_EVT  = 4'h8;
  localparam logic [3:0] REG_STAT = 4'hC;

  typedef enum logic [1:0] {
    SEL_SW,
    SEL_BTN,
    SEL_EVT,
    SEL_STAT
  } reg_sel_t;

  function automatic reg_sel_t reg_sel(
    input logic [3:0] off
  );
    reg_sel_t s;
    case (off & 4'hC)
      REG_SW:   s = SEL_SW;
      REG_BTN:  s = SEL_BTN;
      REG_EVT:  s = SEL_EVT;
      REG_STAT: s = SEL_STAT;
      default:  s = SEL_SW;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// One-bit synchroniser plus 3-sample debouncer.
// Samples are taken only on the shared tick.
module input_debouncer (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic rise
);

  logic       s1;
  logic       s2;
  logic [2:0] hist;
  logic [2:0] hist_nx;
  logic       agree;

  assign hist_nx = {hist[1:0], s2};
  assign agree = (hist_nx == 3'b111) ||
                 (hist_nx == 3'b000);
  // rise lines up with the edge where db goes high
  assign rise = tick && (hist_nx == 3'b111) && !db;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 3'b000;
      db   <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (tick) begin
        hist <= hist_nx;
        if (agree) db <= hist_nx[0];
      end
    end
  end

endmodule

// File: rtl/board_input_reader.sv
// Debounced switches/buttons as read-only registers,
// with sticky clear-on-read press events and an irq.
module board_input_reader
  import io_map_pkg::*;
#(
  parameter int          NUM_SW          = 16,
  parameter int          NUM_BTN         = 5,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [31:0] BASE_ADDR       = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [31:0]        bus_addr,
  input  logic               bus_rd_en,
  output logic [31:0]        bus_rd_data,
  output logic               bus_rd_valid,
  output logic               irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]      cnt;
  logic               tick;
  logic               tick_seen;
  logic [NUM_SW-1:0]  sw_db;
  logic [NUM_SW-1:0]  sw_rise_unused;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] evt_nx;
  logic               in_win;
  logic               clr;
  reg_sel_t           sel;
  logic [31:0]        rd_val;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + CW'(1);
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    input_debouncer u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (sw[i]),
      .tick  (tick),
      .db    (sw_db[i]),
      .rise  (sw_rise_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    input_debouncer u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn[i]),
      .tick  (tick),
      .db    (btn_db[i]),
      .rise  (btn_rise[i])
    );
  end

  assign in_win = bus_rd_en &&
    (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign sel = reg_sel(bus_addr[3:0]);
  assign clr = in_win && (sel == SEL_EVT);
  // a press at the clearing edge survives the clear
  assign evt_nx = (clr ? '0 : evt) | btn_rise;

  always_comb begin
    rd_val = '0;
    unique case (sel)
      SEL_SW:   rd_val[NUM_SW-1:0]  = sw_db;
      SEL_BTN:  rd_val[NUM_BTN-1:0] = btn_db;
      SEL_EVT:  rd_val[NUM_BTN-1:0] = evt;
      SEL_STAT: rd_val[1:0] = {irq, tick_seen};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt          <= '0;
      irq          <= 1'b0;
      tick_seen    <= 1'b0;
      bus_rd_valid <= 1'b0;
      bus_rd_data  <= '0;
    end else begin
      evt          <= evt_nx;
      irq          <= |evt_nx;
      tick_seen    <= tick_seen | tick;
      bus_rd_valid <= in_win;
      if (in_win) bus_rd_data <= rd_val;
    end
  end

endmodule
